// File: rtl/vga_timing_gen.sv
// Raster timing generator: divides the system clock down to a pixel tick,
// walks the horizontal/vertical counters over the full raster and produces
// sync, blanking and line/frame markers aligned to the counter values.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst,
  output logic        pix_en,
  output logic [15:0] H_Counter_Value,
  output logic [15:0] V_Counter_Value,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        line_end,
  output logic        frame_end
);

  // A one-bit divider is kept even for CLK_DIV=1; it then simply stays at 0.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [15:0] H_LAST    = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [15:0] V_LAST    = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [15:0] H_ACT     = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT     = 16'(V_ACTIVE);
  localparam logic [15:0] HS_START  = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_STOP   = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VS_START  = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_STOP   = 16'(V_ACTIVE + V_FP + V_SYNC);

  // Active-low sync decode: low while cnt is inside [start, stop).
  function automatic logic sync_n(input logic [15:0] cnt,
                                  input logic [15:0] start,
                                  input logic [15:0] stop);
    return !((cnt >= start) && (cnt < stop));
  endfunction

  logic [DIV_W-1:0] div_q, div_d;
  logic [15:0]      h_q, h_d;
  logic [15:0]      v_q, v_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_on_q, video_on_d;

  // Markers are decoded straight from registered state so they sit exactly
  // one clock before the edge on which the counters wrap.
  assign pix_en          = (div_q == DIV_LAST);
  assign line_end        = pix_en && (h_q == H_LAST);
  assign frame_end       = line_end && (v_q == V_LAST);
  assign H_Counter_Value = h_q;
  assign V_Counter_Value = v_q;
  assign hsync           = hsync_q;
  assign vsync           = vsync_q;
  assign video_on        = video_on_q;

  // Next-state: divider, counters, and sync/blank decoded from the next
  // counter values so the registered outputs move with the counters.
  always_comb begin
    div_d = div_q;
    h_d   = h_q;
    v_d   = v_q;
    if (pix_en) begin
      div_d = '0;
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? 16'd0 : v_q + 16'd1;
      end else begin
        h_d = h_q + 16'd1;
      end
    end else begin
      div_d = div_q + 1'b1;
    end
    hsync_d    = sync_n(h_d, HS_START, HS_STOP);
    vsync_d    = sync_n(v_d, VS_START, VS_STOP);
    video_on_d = (h_d < H_ACT) && (v_d < V_ACT);
  end

  // State registers; reset puts the raster at (0,0), which is visible video.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q      <= '0;
      h_q        <= '0;
      v_q        <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      video_on_q <= 1'b1;
    end else begin
      div_q      <= div_d;
      h_q        <= h_d;
      v_q        <= v_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      video_on_q <= video_on_d;
    end
  end

endmodule
